soc_run_ctrl: RTL and testbench
===============================

# soc_run_ctrl

Parametrised reset-sequencing and run-control unit for the minimal SoC. On a start request it holds a configurable set of reset channels asserted for a fixed number of cycles, releases them one by one in a staggered order, then counts run cycles until a cycle budget expires and the SoC is frozen back into reset. It replaces the fixed-delay reset and fixed-length stop timing with synthesizable, per-channel sequencing and supports pause, abort and relaunch.

## Interface
Parameters:
- NUM_RST, 3: number of reset channels, 1..8; channel 0 releases first.
- HOLD_CYCLES, 4: cycles all channels stay asserted after start, ≥1.
- STAGGER, 2: cycles between successive channel releases, ≥0.
- RUN_CYCLES, 200: run budget in unpaused cycles; 0 means unlimited.
- CNT_W, 16: width of the run counter; RUN_CYCLES < 2^CNT_W.
- WDOG_CYCLES, 32: watchdog limit, used only with SOC_RUN_WDOG_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  launch request, sampled in IDLE or DONE.
- pause  in  1  freezes the run counter in RUN.
- abort  in  1  return to IDLE from any state.
- kick  in  1  watchdog refresh, ignored without SOC_RUN_WDOG_EN.
- rst_o  out  NUM_RST  per-channel reset to the SoC, 1 = asserted.
- run_cnt_o  out  CNT_W  unpaused cycles counted in the current run.
- running_o  out  1  high in RUN.
- done_o  out  1  high in DONE.
- state_o  out  3  encoded state: IDLE=0, HOLD=1, RELEASE=2, RUN=3, DONE=4.

## Operation
- Reset (rst low at an edge) forces IDLE, rst_o all ones, run_cnt_o 0, running_o 0, done_o 0, and internal counters 0.
- Priority at each edge: rst, then abort, then watchdog expiry, then normal transitions.
- IDLE: rst_o all ones. start=1 → HOLD, hold counter cleared.
- HOLD: rst_o all ones. After HOLD_CYCLES cycles in HOLD → RELEASE, or straight to RUN when NUM_RST=1 or STAGGER=0.
- Release timing: channel i drops at edge E0 + i·STAGGER, where E0 is the edge leaving HOLD. With STAGGER=0, all channels drop at E0.
- Released channels stay low until IDLE or DONE.
- RELEASE → RUN on the edge that drops channel NUM_RST-1.
- RUN: run_cnt_o increments by 1 each edge with pause=0 and holds when pause=1.
  - When the increment produces RUN_CYCLES (RUN_CYCLES≠0) → DONE.
  - With RUN_CYCLES=0, the counter wraps modulo 2^CNT_W and the state never leaves RUN on its own.
- DONE: rst_o all ones (core frozen), done_o 1, run_cnt_o holds its final value.
  - start=1 → HOLD with run_cnt_o cleared to 0 on the same edge.
- abort=1 in any state → IDLE on the next edge. Outputs then take their IDLE values, except run_cnt_o, which also clears.
- start while in HOLD, RELEASE or RUN is ignored.
- pause outside RUN is ignored; pause does not delay HOLD or RELEASE.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- start sampled high at edge T:
  - state_o = 1 after T.
  - rst_o[i] low after edge T + HOLD_CYCLES + i·STAGGER.
  - running_o high after edge T + HOLD_CYCLES + (NUM_RST-1)·STAGGER.
- done_o rises after the edge on which run_cnt_o reaches RUN_CYCLES; both update on the same edge.
- abort: every rst_o bit is high one edge after abort is sampled.
- rst low for one edge mid-sequence fully restarts the block; no partial release survives.

## Configuration
- SOC_RUN_WDOG_EN defined: a watchdog counter runs in RUN only.
  - It clears on kick=1 and on entry to RUN.
  - When it reaches WDOG_CYCLES without a kick, the block → HOLD on that edge. rst_o all ones, run_cnt_o keeps its value, and the normal HOLD/RELEASE sequence reruns.
  - pause does not stop the watchdog.
- SOC_RUN_WDOG_EN undefined: no watchdog logic; kick is unused; RUN exits only on budget, abort or rst.

## Test plan
- Defaults (NUM_RST=3, HOLD_CYCLES=4, STAGGER=2, RUN_CYCLES=10), start pulsed at edge 5:
  - rst_o goes 111→110 at edge 9, 100 at edge 11, 000 at edge 13.
  - running_o is high from edge 13.
  - done_o and rst_o=111 at edge 23, run_cnt_o=10.
- Same setup, pause held for 3 cycles mid-run: done_o is delayed to edge 26, run_cnt_o=10.
- abort at edge 10 (rst_o=110): rst_o=111 and state_o=0 after edge 11; a new start at edge 15 repeats the sequence from edge 19.
- rst low at edge 12: all outputs return to reset values after edge 12; start ignored while rst low.
- NUM_RST=1, STAGGER=0, RUN_CYCLES=0: state skips RELEASE; run_cnt_o with CNT_W=4 wraps 15→0 while running_o stays 1.
- With SOC_RUN_WDOG_EN, WDOG_CYCLES=5, no kick in RUN: state_o=1 five cycles after RUN entry and rst_o=111; kick every 3 cycles keeps RUN until done_o.

Source files
------------

// File: rtl/soc_run_ctrl.sv
// Reset-sequencing and run-control unit: hold all reset channels, release them staggered,
// count a run budget, then freeze the SoC. Optional watchdog enabled by SOC_RUN_WDOG_EN.
module soc_run_ctrl #(
    parameter int NUM_RST     = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 2,
    parameter int RUN_CYCLES  = 200,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic               kick,
    output logic [NUM_RST-1:0] rst_o,
    output logic [CNT_W-1:0]   run_cnt_o,
    output logic               running_o,
    output logic               done_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_REL  = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0]    STAG_LAST = SW'((STAGGER > 0) ? STAGGER - 1 : 0);
    localparam logic [CNT_W-1:0] RUN_TGT   = CNT_W'(RUN_CYCLES);
    // With one channel or no stagger every channel drops on the edge leaving HOLD.
    localparam bit DIRECT = (NUM_RST == 1) || (STAGGER == 0);

    state_t             state;
    logic [HW-1:0]      hold_cnt;
    logic [SW-1:0]      stag_cnt;
    logic [NUM_RST-1:0] nxt;
    logic [CNT_W-1:0]   run_inc;
    logic               wdog_fire;

    assign run_inc = run_cnt_o + CNT_W'(1);
    assign state_o = state;

`ifdef SOC_RUN_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;

    // Held at zero outside RUN, so it is always clear on RUN entry; pause does not stop it.
    always_ff @(posedge clk) begin
        if (!rst || state != S_RUN || kick)
            wdog_cnt <= '0;
        else
            wdog_cnt <= wdog_cnt + WW'(1);
    end

    assign wdog_fire = (state == S_RUN) && !kick && (wdog_cnt + WW'(1) == WW'(WDOG_CYCLES));
`else
    logic unused_wdog;
    assign unused_wdog = kick | (WDOG_CYCLES == 0);
    assign wdog_fire   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst || abort) begin
            state     <= S_IDLE;
            rst_o     <= '1;
            run_cnt_o <= '0;
            running_o <= 1'b0;
            done_o    <= 1'b0;
            hold_cnt  <= '0;
            stag_cnt  <= '0;
            nxt       <= '0;
        end else if (wdog_fire) begin
            // Watchdog reruns the reset sequence but keeps the run count.
            state     <= S_HOLD;
            rst_o     <= '1;
            running_o <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_HOLD;
                        hold_cnt  <= '0;
                        run_cnt_o <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (DIRECT) begin
                            rst_o     <= '0;
                            state     <= S_RUN;
                            running_o <= 1'b1;
                        end else begin
                            rst_o    <= ~NUM_RST'(1);
                            nxt      <= NUM_RST'(2);
                            stag_cnt <= '0;
                            state    <= S_REL;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_REL: begin
                    // nxt is a one-hot pointer to the next channel to drop.
                    if (stag_cnt == STAG_LAST) begin
                        stag_cnt <= '0;
                        rst_o    <= rst_o & ~nxt;
                        nxt      <= nxt << 1;
                        if (nxt[NUM_RST-1]) begin
                            state     <= S_RUN;
                            running_o <= 1'b1;
                        end
                    end else begin
                        stag_cnt <= stag_cnt + SW'(1);
                    end
                end
                S_RUN: begin
                    if (!pause) begin
                        run_cnt_o <= run_inc;
                        if ((RUN_CYCLES != 0) && (run_inc == RUN_TGT)) begin
                            state     <= S_DONE;
                            rst_o     <= '1;
                            running_o <= 1'b0;
                            done_o    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state     <= S_HOLD;
                        done_o    <= 1'b0;
                        hold_cnt  <= '0;
                        run_cnt_o <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    rst_o <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_run_ctrl.sv
// Table-driven scoreboard bench for soc_run_ctrl; three instances cover the default,
// single-channel wrapping and watchdog configurations.
module tb_soc_run_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, pause = 1'b0, abort = 1'b0, kick = 1'b0;

    logic [2:0]  a_rst, c_rst;
    logic [15:0] a_cnt, c_cnt;
    logic        a_run, a_dn, b_run, b_dn, c_run, c_dn;
    logic [2:0]  a_st, b_st, c_st;
    logic [0:0]  b_rst;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    soc_run_ctrl #(.RUN_CYCLES(10)) dut_a (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort), .kick(kick),
        .rst_o(a_rst), .run_cnt_o(a_cnt), .running_o(a_run), .done_o(a_dn), .state_o(a_st)
    );

    soc_run_ctrl #(.NUM_RST(1), .STAGGER(0), .RUN_CYCLES(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort), .kick(kick),
        .rst_o(b_rst), .run_cnt_o(b_cnt), .running_o(b_run), .done_o(b_dn), .state_o(b_st)
    );

    soc_run_ctrl #(.RUN_CYCLES(20), .WDOG_CYCLES(5)) dut_c (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort), .kick(kick),
        .rst_o(c_rst), .run_cnt_o(c_cnt), .running_o(c_run), .done_o(c_dn), .state_o(c_st)
    );

    typedef struct {
        int         sc;
        int         dut;
        int         edge_n;
        logic [7:0] rst;
        logic [2:0] st;
        logic       run;
        logic       dn;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(int sc, int dut, int e, logic [7:0] r, logic [2:0] st,
                                logic run, logic dn, logic [15:0] cnt);
        vec_t v;
        v.sc = sc; v.dut = dut; v.edge_n = e; v.rst = r; v.st = st;
        v.run = run; v.dn = dn; v.cnt = cnt;
        return v;
    endfunction

    task automatic compare(input vec_t v);
        logic [7:0]  r;
        logic [2:0]  st;
        logic        run, dn;
        logic [15:0] cnt;
        case (v.dut)
            0:       begin r = {5'd0, a_rst}; st = a_st; run = a_run; dn = a_dn; cnt = a_cnt; end
            1:       begin r = {7'd0, b_rst}; st = b_st; run = b_run; dn = b_dn; cnt = {12'd0, b_cnt}; end
            default: begin r = {5'd0, c_rst}; st = c_st; run = c_run; dn = c_dn; cnt = c_cnt; end
        endcase
        checks++;
        if (r !== v.rst || st !== v.st || run !== v.run || dn !== v.dn || cnt !== v.cnt) begin
            errors++;
            $display("FAIL s%0d dut%0d edge%0d: got rst=%b st=%0d run=%b done=%b cnt=%0d, want rst=%b st=%0d run=%b done=%b cnt=%0d",
                     v.sc, v.dut, v.edge_n, r, st, run, dn, cnt, v.rst, v.st, v.run, v.dn, v.cnt);
        end
    endtask

    task automatic check_edge(input int n);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].edge_n == n) begin
                compare(sb[i]);
                sb.delete(i);
            end
        end
    endtask

    task automatic set_inputs(input int sc, input int n);
        rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; kick = 1'b0;
        case (sc)
            1: start = (n == 5 || n == 16);
            2: begin
                start = (n == 5);
                pause = (n >= 6 && n <= 8) || (n >= 16 && n <= 18);
            end
            3: begin
                start = (n == 5 || n == 15);
                abort = (n == 11);
            end
            4: begin
                start = (n == 5 || n == 12);
                rst   = (n != 12);
            end
            default: begin
                start = (n == 5);
                kick  = (n >= 26) && (n % 3 == 1);
            end
        endcase
    endtask

    task automatic reset_dut();
        rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; kick = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_scen(input int sc, input int last);
        foreach (tbl[i]) if (tbl[i].sc == sc) sb.push_back(tbl[i]);
        check_edge(0);
        for (int n = 1; n <= last; n++) begin
            set_inputs(sc, n);
            @(posedge clk);
            #1 check_edge(n);
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0; kick = 1'b0; rst = 1'b1;
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL s%0d unreached edge %0d: got none, want a check", sc, sb[0].edge_n);
            sb.delete(0);
        end
    endtask

    initial begin
        // Scenario 1: nominal launch, start pulse at edge 5, extra start in RUN ignored.
        tbl.push_back(mk(1, 0,  0, 8'b111, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1,  0, 8'b1,   0, 0, 0, 0));
        tbl.push_back(mk(1, 2,  0, 8'b111, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,  4, 8'b111, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0,  5, 8'b111, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0,  8, 8'b111, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0,  9, 8'b110, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 10, 8'b110, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 11, 8'b100, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 12, 8'b100, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 13, 8'b000, 3, 1, 0, 0));
        tbl.push_back(mk(1, 0, 18, 8'b000, 3, 1, 0, 5));
        tbl.push_back(mk(1, 0, 22, 8'b000, 3, 1, 0, 9));
        tbl.push_back(mk(1, 0, 23, 8'b111, 4, 0, 1, 10));
        tbl.push_back(mk(1, 0, 25, 8'b111, 4, 0, 1, 10));
        // Scenario 2: relaunch from DONE, pause in HOLD (ignored) and 3 cycles in RUN.
        tbl.push_back(mk(2, 0,  4, 8'b111, 4, 0, 1, 10));
        tbl.push_back(mk(2, 0,  5, 8'b111, 1, 0, 0, 0));
        tbl.push_back(mk(2, 0,  9, 8'b110, 2, 0, 0, 0));
        tbl.push_back(mk(2, 0, 13, 8'b000, 3, 1, 0, 0));
        tbl.push_back(mk(2, 0, 17, 8'b000, 3, 1, 0, 2));
        tbl.push_back(mk(2, 0, 25, 8'b000, 3, 1, 0, 9));
        tbl.push_back(mk(2, 0, 26, 8'b111, 4, 0, 1, 10));
        // Scenario 3: abort mid-release, then relaunch.
        tbl.push_back(mk(3, 0,  0, 8'b111, 0, 0, 0, 0));
        tbl.push_back(mk(3, 0, 10, 8'b110, 2, 0, 0, 0));
        tbl.push_back(mk(3, 0, 11, 8'b111, 0, 0, 0, 0));
        tbl.push_back(mk(3, 0, 14, 8'b111, 0, 0, 0, 0));
        tbl.push_back(mk(3, 0, 15, 8'b111, 1, 0, 0, 0));
        tbl.push_back(mk(3, 0, 19, 8'b110, 2, 0, 0, 0));
        tbl.push_back(mk(3, 0, 23, 8'b000, 3, 1, 0, 0));
        // Scenario 4: reset low at edge 12 with start high.
        tbl.push_back(mk(4, 0, 11, 8'b100, 2, 0, 0, 0));
        tbl.push_back(mk(4, 0, 12, 8'b111, 0, 0, 0, 0));
        tbl.push_back(mk(4, 0, 13, 8'b111, 0, 0, 0, 0));
        tbl.push_back(mk(4, 0, 16, 8'b111, 0, 0, 0, 0));
        // Scenario 5: single channel skips RELEASE and wraps; watchdog instance.
        tbl.push_back(mk(5, 1,  5, 8'b1, 1, 0, 0, 0));
        tbl.push_back(mk(5, 1,  8, 8'b1, 1, 0, 0, 0));
        tbl.push_back(mk(5, 1,  9, 8'b0, 3, 1, 0, 0));
        tbl.push_back(mk(5, 1, 24, 8'b0, 3, 1, 0, 15));
        tbl.push_back(mk(5, 1, 25, 8'b0, 3, 1, 0, 0));
        tbl.push_back(mk(5, 1, 26, 8'b0, 3, 1, 0, 1));
        tbl.push_back(mk(5, 2, 17, 8'b000, 3, 1, 0, 4));
`ifdef SOC_RUN_WDOG_EN
        tbl.push_back(mk(5, 2, 18, 8'b111, 1, 0, 0, 4));
        tbl.push_back(mk(5, 2, 22, 8'b110, 2, 0, 0, 4));
        tbl.push_back(mk(5, 2, 26, 8'b000, 3, 1, 0, 4));
        tbl.push_back(mk(5, 2, 41, 8'b000, 3, 1, 0, 19));
        tbl.push_back(mk(5, 2, 42, 8'b111, 4, 0, 1, 20));
`else
        tbl.push_back(mk(5, 2, 18, 8'b000, 3, 1, 0, 5));
        tbl.push_back(mk(5, 2, 32, 8'b000, 3, 1, 0, 19));
        tbl.push_back(mk(5, 2, 33, 8'b111, 4, 0, 1, 20));
`endif

        reset_dut();
        run_scen(1, 25);
        run_scen(2, 27);
        reset_dut();
        run_scen(3, 24);
        reset_dut();
        run_scen(4, 16);
        reset_dut();
        run_scen(5, 44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
